// File: rtl/mem_req_pkg.sv
// Shared types and constants for the data-side memory request controller.
package mem_req_pkg;

    localparam int unsigned ADDR_W          = 16;
    localparam int unsigned DATA_W          = 16;
    localparam int unsigned TIMER_W         = 8;
    localparam int unsigned DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Command presented to the memory system, held stable for a whole access.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              rd;
        logic              wr;
    } mem_cmd_t;

endpackage

// File: rtl/mem_req_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (inc && !(&q)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// One-at-a-time load/store controller in front of the cache memory system.
// Performance counters are built only when MEM_REQ_CTRL_PERF_EN is defined.
module mem_req_ctrl
    import mem_req_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [15:0]       req_addr,
    input  logic [15:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [15:0]       resp_rdata,
    output logic              resp_err,
    output logic              pipe_stall,
    output logic [15:0]       mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_done,
    input  logic              mem_stall,
    input  logic              mem_hit,
    input  logic              mem_err,
    input  logic [15:0]       mem_rdata,
    output logic [PERF_W-1:0] perf_access,
    output logic [PERF_W-1:0] perf_hit
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    state_t               state, state_n;
    mem_cmd_t             cmd, cmd_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic                 resp_valid_n;
    logic                 resp_err_n;
    logic [DATA_W-1:0]    resp_rdata_n;
    logic                 req_ready_n;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Registered command, response and timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd        <= '0;
            timer      <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
        end else begin
            cmd        <= cmd_n;
            timer      <= timer_n;
            resp_valid <= resp_valid_n;
            resp_err   <= resp_err_n;
            resp_rdata <= resp_rdata_n;
            req_ready  <= req_ready_n;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_n      = state;
        cmd_n        = cmd;
        timer_n      = timer;
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        resp_rdata_n = resp_rdata;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!req_addr[0]) begin
                        cmd_n.addr  = req_addr;
                        cmd_n.wdata = req_wdata;
                        cmd_n.rd    = !req_wr;
                        cmd_n.wr    = req_wr;
                        timer_n     = '0;
                        state_n     = BUSY;
                    end else begin
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                        resp_rdata_n = '0;
                        state_n      = ERR;
                    end
                end
            end
            BUSY: begin
                timer_n = timer + TIMER_W'(1);
                // Error outranks done; done outranks the timeout on the last cycle.
                if (mem_err || (!mem_done && timer == TIMER_LAST)) begin
                    cmd_n.rd     = 1'b0;
                    cmd_n.wr     = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b1;
                    resp_rdata_n = '0;
                    state_n      = ERR;
                end else if (mem_done) begin
                    cmd_n.rd     = 1'b0;
                    cmd_n.wr     = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = mem_rdata;
                    state_n      = RESP;
                end
            end
            RESP: state_n = IDLE;
            ERR:  state_n = IDLE;
            default: state_n = IDLE;
        endcase

        req_ready_n = (state_n == IDLE);
    end

    assign mem_addr   = cmd.addr;
    assign mem_wdata  = cmd.wdata;
    assign mem_rd     = cmd.rd;
    assign mem_wr     = cmd.wr;
    assign pipe_stall = (state != IDLE) | req_valid;

`ifdef MEM_REQ_CTRL_PERF_EN
    logic hit_flag;
    logic access_ok;
    logic unused_inputs;

    // Hit status is only meaningful in the first BUSY cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_flag <= 1'b0;
        end else if (state == BUSY && timer == '0) begin
            hit_flag <= mem_hit;
        end
    end

    assign access_ok     = resp_valid & ~resp_err;
    assign unused_inputs = &{1'b0, mem_stall};

    sat_counter #(.W(PERF_W)) u_perf_access (
        .clk (clk),
        .rst (rst),
        .inc (access_ok),
        .q   (perf_access)
    );

    sat_counter #(.W(PERF_W)) u_perf_hit (
        .clk (clk),
        .rst (rst),
        .inc (access_ok & hit_flag),
        .q   (perf_hit)
    );
`else
    logic unused_inputs;

    assign unused_inputs = &{1'b0, mem_stall, mem_hit};
    assign perf_access   = '0;
    assign perf_hit      = '0;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: acts as pipeline and memory system, checks against a transaction model.
module tb_mem_req_ctrl;

    localparam int unsigned TMO  = 24;
    localparam int unsigned PW   = 2;
    localparam int unsigned PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_wr;
    logic [15:0]   req_addr, req_wdata;
    logic          req_ready, resp_valid, resp_err, pipe_stall;
    logic [15:0]   resp_rdata, mem_addr, mem_wdata;
    logic          mem_rd, mem_wr;
    logic          mem_done, mem_stall, mem_hit, mem_err;
    logic [15:0]   mem_rdata;
    logic [PW-1:0] perf_access, perf_hit;

    int checks = 0;
    int errors = 0;
    int m_acc  = 0;
    int m_hit  = 0;

    always #5 clk = ~clk;

    mem_req_ctrl #(.TIMEOUT(TMO), .PERF_W(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .pipe_stall  (pipe_stall),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_done    (mem_done),
        .mem_stall   (mem_stall),
        .mem_hit     (mem_hit),
        .mem_err     (mem_err),
        .mem_rdata   (mem_rdata),
        .perf_access (perf_access),
        .perf_hit    (perf_hit)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete transaction. lat = BUSY cycle (1-based) on which the memory answers;
    // lat beyond TMO means the memory never answers.
    task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          input int lat, input logic err, input logic hit, input logic [15:0] rdata);
        int   busy;
        logic exp_err;
        exp_err = addr[0] || (lat > int'(TMO)) || err;
        busy    = addr[0] ? 0 : ((lat > int'(TMO)) ? int'(TMO) : lat);

        chk("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        mem_done  = 1'b0;
        mem_err   = 1'b0;
        step();

        for (int c = 1; c <= busy; c++) begin
            chk("busy_rd",    32'(mem_rd),     32'(!wr));
            chk("busy_wr",    32'(mem_wr),     32'(wr));
            chk("busy_addr",  32'(mem_addr),   32'(addr));
            chk("busy_wdata", 32'(mem_wdata),  32'(wdata));
            chk("busy_ready", 32'(req_ready),  32'd0);
            chk("busy_rv",    32'(resp_valid), 32'd0);
            chk("busy_stall", 32'(pipe_stall), 32'd1);
            req_valid = 1'($urandom);
            req_wr    = 1'($urandom);
            req_addr  = 16'($urandom);
            req_wdata = 16'($urandom);
            mem_stall = 1'($urandom);
            mem_hit   = (c == 1) ? hit : 1'($urandom);
            mem_err   = err && (c == lat);
            mem_done  = (c == lat) ? (err ? 1'($urandom) : 1'b1) : 1'b0;
            mem_rdata = (c == lat && !err) ? rdata : 16'($urandom);
            step();
        end

        chk("end_rd",    32'(mem_rd),     32'd0);
        chk("end_wr",    32'(mem_wr),     32'd0);
        chk("end_rv",    32'(resp_valid), 32'd1);
        chk("end_err",   32'(resp_err),   32'(exp_err));
        chk("end_rdata", 32'(resp_rdata), exp_err ? 32'd0 : 32'(rdata));
        chk("end_ready", 32'(req_ready),  32'd0);
        chk("end_stall", 32'(pipe_stall), 32'd1);
        req_valid = 1'b0;
        mem_done  = 1'b0;
        mem_err   = 1'b0;
`ifdef MEM_REQ_CTRL_PERF_EN
        if (!exp_err) begin
            if (m_acc < int'(PMAX)) m_acc++;
            if (hit && m_hit < int'(PMAX)) m_hit++;
        end
`endif
        step();

        chk("post_rv",    32'(resp_valid),  32'd0);
        chk("post_ready", 32'(req_ready),   32'd1);
        chk("post_stall", 32'(pipe_stall),  32'd0);
        chk("perf_acc",   32'(perf_access), 32'(m_acc));
        chk("perf_hit",   32'(perf_hit),    32'(m_hit));
    endtask

    initial begin
        int r;
        int lat;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        mem_done  = 1'b0;
        mem_stall = 1'b0;
        mem_hit   = 1'b0;
        mem_err   = 1'b0;
        mem_rdata = '0;

        // Reset state
        @(negedge clk);
        chk("rst_rd",    32'(mem_rd),      32'd0);
        chk("rst_wr",    32'(mem_wr),      32'd0);
        chk("rst_addr",  32'(mem_addr),    32'd0);
        chk("rst_rv",    32'(resp_valid),  32'd0);
        chk("rst_ready", 32'(req_ready),   32'd1);
        chk("rst_pacc",  32'(perf_access), 32'd0);
        rst = 1'b1;
        step();

        // Directed: hit load, long-miss store, misaligned, error, timeout, done on last cycle
        access(1'b0, 16'h0010, 16'h0000, 1,  1'b0, 1'b1, 16'hBEEF);
        access(1'b1, 16'h0124, 16'h1234, 21, 1'b0, 1'b0, 16'h5A5A);
        access(1'b0, 16'h0003, 16'h0000, 1,  1'b0, 1'b0, 16'h0000);
        access(1'b0, 16'h0200, 16'h0000, 2,  1'b1, 1'b1, 16'h0000);
        access(1'b0, 16'h0300, 16'h0000, int'(TMO) + 5, 1'b0, 1'b0, 16'h0000);
        access(1'b1, 16'h0302, 16'hCAFE, int'(TMO), 1'b0, 1'b1, 16'h7777);

        // Saturation: a run of hits, then an error that must not count
        for (int i = 0; i < 5; i++)
            access(1'b0, 16'h0040 + 16'(i * 2), 16'h0000, 1, 1'b0, 1'b1, 16'(16'h1000 + i));
        access(1'b0, 16'h0050, 16'h0000, 1, 1'b1, 1'b1, 16'h0000);

        // Asynchronous reset in the middle of BUSY
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 16'h0080;
        step();
        req_valid = 1'b0;
        step();
        #2 rst = 1'b0;
        #1;
        chk("arst_rd",    32'(mem_rd),      32'd0);
        chk("arst_wr",    32'(mem_wr),      32'd0);
        chk("arst_addr",  32'(mem_addr),    32'd0);
        chk("arst_rv",    32'(resp_valid),  32'd0);
        chk("arst_ready", 32'(req_ready),   32'd1);
        chk("arst_pacc",  32'(perf_access), 32'd0);
        chk("arst_phit",  32'(perf_hit),    32'd0);
        m_acc = 0;
        m_hit = 0;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rel_rv",    32'(resp_valid), 32'd0);
        chk("rel_ready", 32'(req_ready),  32'd1);
        chk("rel_stall", 32'(pipe_stall), 32'd0);

        // Randomized transactions
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       lat = int'($urandom_range(1, 4));
            else if (r == 6) lat = int'(TMO);
            else if (r == 7) lat = int'(TMO) + 1;
            else             lat = 1;
            access(1'($urandom),
                   ($urandom_range(0, 5) == 0) ? 16'($urandom) | 16'h0001 : 16'($urandom) & 16'hFFFE,
                   16'($urandom), lat,
                   ($urandom_range(0, 7) == 0), 1'($urandom), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
